// File: rtl/quad_lo_pkg.sv
// -----------------------------------------------------------------------------
// quad_lo_pkg
// Shared types and constants for the quadrature LO sequencer.
//   - lo_state_e  : control FSM encoding (IDLE / RUN / PEND)
//   - PH0..PH3    : phase indices of the divide-by-4 I/Q scheme
//   - *_MASK      : per-phase output patterns, bit n = level during phase n
//   - iq_decode   : returns {i, q} for a given phase and sideband select
// -----------------------------------------------------------------------------
package quad_lo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } lo_state_e;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    // Every pattern is low in at least one of the edge phases (0 or 3), so a
    // period boundary never falls inside a pulse on either output.
    localparam logic [3:0] I_MASK      = 4'b0110;
    localparam logic [3:0] Q_LAG_MASK  = 4'b1100;
    localparam logic [3:0] Q_LEAD_MASK = 4'b0011;

    function automatic logic [1:0] iq_decode(input logic [1:0] ph, input logic swap);
        logic q_bit;
        q_bit = swap ? Q_LEAD_MASK[ph] : Q_LAG_MASK[ph];
        return {I_MASK[ph], q_bit};
    endfunction

endpackage

// File: rtl/quadrature_phase_gen.sv
// -----------------------------------------------------------------------------
// quadrature_phase_gen
// Prescaler + 2-bit phase counter with registered I/Q decode.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   div_eff    divide ratio currently in force (>= 1)
//   swap_next  sideband select that will be in force next cycle
//   run        generator is active next cycle
//   load       restart at phase 0 / prescaler 0 next cycle
//   phase      current phase index
//   boundary   last cycle of a full output period (tc in phase 3)
//   out_i      registered in-phase clock
//   out_q      registered quadrature clock
// -----------------------------------------------------------------------------
module quadrature_phase_gen
    import quad_lo_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_eff,
    input  logic             swap_next,
    input  logic             run,
    input  logic             load,
    output logic [1:0]       phase,
    output logic             boundary,
    output logic             out_i,
    output logic             out_q
);

    logic [DIV_W-1:0] pre_q, pre_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       iq_q, iq_d;
    logic             tc;

    assign tc       = (pre_q == (div_eff - DIV_W'(1)));
    assign boundary = tc && (phase_q == PH3);

    always_comb begin
        pre_d   = pre_q;
        phase_d = phase_q;
        iq_d    = 2'b00;
        if (load || !run) begin
            pre_d   = '0;
            phase_d = PH0;
        end else if (tc) begin
            pre_d   = '0;
            phase_d = phase_q + 2'd1;
        end else begin
            pre_d   = pre_q + DIV_W'(1);
        end
        // Decode from the next phase so outputs change on the same edge as phase.
        if (run) begin
            iq_d = iq_decode(phase_d, swap_next);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            phase_q <= PH0;
            iq_q    <= 2'b00;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            iq_q    <= iq_d;
        end
    end

    assign phase = phase_q;
    assign out_i = iq_q[1];
    assign out_q = iq_q[0];

endmodule

// File: rtl/quadrature_lo_sequencer.sv
// -----------------------------------------------------------------------------
// quadrature_lo_sequencer
// Glitch-free quadrature LO controller (divide-by-4 I/Q scheme). Settings
// arrive over a valid/ready handshake and take effect only in IDLE or at a
// full-period boundary, so out_i/out_q never produce runt pulses.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   cfg_valid  configuration word valid
//   cfg_ready  configuration can be accepted (low while a change is pending)
//   cfg_div    divide ratio, 0 treated as 1; f_out = f_clk / (4 * div)
//   cfg_swap   0: Q lags I by 90 deg, 1: Q leads I by 90 deg
//   cfg_en     1: run, 0: stop at next boundary
//   out_i      in-phase clock (registered)
//   out_q      quadrature clock (registered)
//   running    high while generating
//   phase      current phase index 0..3
// -----------------------------------------------------------------------------
module quadrature_lo_sequencer
    import quad_lo_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int RST_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_swap,
    input  logic             cfg_en,
    output logic             out_i,
    output logic             out_q,
    output logic             running,
    output logic [1:0]       phase
);

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    localparam logic [DIV_W-1:0] RST_DIV_EFF = eff_div(DIV_W'(RST_DIV));

    lo_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             swap_q, swap_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             sh_swap_q, sh_swap_d;
    logic             sh_en_q, sh_en_d;

    logic xfer;
    logic load;
    logic run;
    logic boundary;

    assign cfg_ready = (state_q != PEND);
    assign xfer      = cfg_valid && cfg_ready;
    assign running   = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        swap_d    = swap_q;
        sh_div_d  = sh_div_q;
        sh_swap_d = sh_swap_q;
        sh_en_d   = sh_en_q;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    div_d  = eff_div(cfg_div);
                    swap_d = cfg_swap;
                    if (cfg_en) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end
                end
            end
            RUN: begin
                // A boundary seen here is deliberately ignored: a word accepted
                // on a boundary cycle waits for the following one.
                if (xfer) begin
                    sh_div_d  = eff_div(cfg_div);
                    sh_swap_d = cfg_swap;
                    sh_en_d   = cfg_en;
                    state_d   = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    div_d  = sh_div_q;
                    swap_d = sh_swap_q;
                    if (sh_en_q) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign run = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= RST_DIV_EFF;
            swap_q    <= 1'b0;
            sh_div_q  <= RST_DIV_EFF;
            sh_swap_q <= 1'b0;
            sh_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            swap_q    <= swap_d;
            sh_div_q  <= sh_div_d;
            sh_swap_q <= sh_swap_d;
            sh_en_q   <= sh_en_d;
        end
    end

    // Prescaler terminal count uses the ratio in force this cycle; the decode
    // uses the sideband that will be in force next cycle.
    quadrature_phase_gen #(
        .DIV_W(DIV_W)
    ) u_phase_gen (
        .clk       (clk),
        .rst       (rst),
        .div_eff   (div_q),
        .swap_next (swap_d),
        .run       (run),
        .load      (load),
        .phase     (phase),
        .boundary  (boundary),
        .out_i     (out_i),
        .out_q     (out_q)
    );

endmodule

// File: tb/tb_quadrature_lo_sequencer.sv
// -----------------------------------------------------------------------------
// tb_quadrature_lo_sequencer
// Directed test of the quadrature LO sequencer. Outputs are sampled on the
// falling clock edge; expected phase/I/Q values come from the cycle index
// within the current setting and the per-phase patterns below.
// -----------------------------------------------------------------------------
module tb_quadrature_lo_sequencer;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_swap;
    logic             cfg_en;
    logic             out_i;
    logic             out_q;
    logic             running;
    logic [1:0]       phase;

    int checks   = 0;
    int failures = 0;

    logic [3:0] i_pat    = 4'b0110;
    logic [3:0] qlag_pat = 4'b1100;
    logic [3:0] qld_pat  = 4'b0011;

    always #5 clk = ~clk;

    quadrature_lo_sequencer #(
        .DIV_W   (DIV_W),
        .RST_DIV (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_swap  (cfg_swap),
        .cfg_en    (cfg_en),
        .out_i     (out_i),
        .out_q     (out_q),
        .running   (running),
        .phase     (phase)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Present a word (called just after a falling edge); waits for ready.
    task automatic send_cfg(input int div, input bit swap, input bit en);
        int waited;
        cfg_valid = 1'b1;
        cfg_div   = div[DIV_W-1:0];
        cfg_swap  = swap;
        cfg_en    = en;
        waited    = 0;
        while (!cfg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cfg_ready) check("cfg_timeout", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        $display("cfg xfer div=%0d swap=%0d en=%0d t=%0t", div, swap, en, $time);
    endtask

    // Check n cycles of running output at cycle offsets k0..k0+n-1 of a setting.
    task automatic watch(input int div, input bit swap, input int k0, input int n, input bit rdy);
        int p;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            p = ((k0 + k) / div) % 4;
            check("running", {31'd0, running}, 32'd1);
            check("phase", {30'd0, phase}, p);
            check("out_i", {31'd0, out_i}, {31'd0, i_pat[p]});
            check("out_q", {31'd0, out_q}, {31'd0, (swap ? qld_pat[p] : qlag_pat[p])});
            check("cfg_ready", {31'd0, cfg_ready}, {31'd0, rdy});
        end
    endtask

    task automatic watch_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle_running", {31'd0, running}, 32'd0);
            check("idle_phase", {30'd0, phase}, 32'd0);
            check("idle_out_i", {31'd0, out_i}, 32'd0);
            check("idle_out_q", {31'd0, out_q}, 32'd0);
            check("idle_ready", {31'd0, cfg_ready}, 32'd1);
        end
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_swap  = 1'b0;
        cfg_en    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_i", {31'd0, out_i}, 32'd0);
        check("rst_out_q", {31'd0, out_q}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_phase", {30'd0, phase}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);
        rst = 1'b1;
        watch_idle(2);

        // div=1, Q lags: phases 0..3, period 4
        send_cfg(1, 1'b0, 1'b1);
        watch(1, 1'b0, 0, 8, 1'b1);

        // div=0 (as 1) with swap, accepted on a boundary cycle: one more old period
        send_cfg(0, 1'b1, 1'b1);
        watch(1, 1'b0, 0, 4, 1'b0);
        watch(1, 1'b1, 0, 8, 1'b1);

        // div=3, Q leads: period 12
        send_cfg(3, 1'b1, 1'b1);
        watch(1, 1'b1, 0, 4, 1'b0);
        watch(3, 1'b1, 0, 24, 1'b1);

        // switch to div=2 (applied after a full old period)
        send_cfg(2, 1'b0, 1'b1);
        watch(3, 1'b1, 0, 12, 1'b0);
        watch(2, 1'b0, 0, 3, 1'b1);

        // mid-period change to div=5: old period finishes, then 20-clock periods
        send_cfg(5, 1'b0, 1'b1);
        watch(2, 1'b0, 3, 5, 1'b0);
        watch(5, 1'b0, 0, 40, 1'b1);

        // stop: full old period, then idle
        send_cfg(1, 1'b0, 1'b0);
        watch(5, 1'b0, 0, 20, 1'b0);
        watch_idle(3);

        // en=0 in IDLE stores but does not start
        send_cfg(7, 1'b1, 1'b0);
        watch_idle(3);

        // start div=2, then reset mid-pulse (phase 2: both outputs high)
        send_cfg(2, 1'b0, 1'b1);
        watch(2, 1'b0, 0, 6, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_i", {31'd0, out_i}, 32'd0);
        check("arst_out_q", {31'd0, out_q}, 32'd0);
        check("arst_running", {31'd0, running}, 32'd0);
        check("arst_phase", {30'd0, phase}, 32'd0);
        check("arst_ready", {31'd0, cfg_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        watch_idle(3);

        // restart after reset
        send_cfg(3, 1'b0, 1'b1);
        watch(3, 1'b0, 0, 12, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/quadrature_lo_sequencer.md
Name: quadrature_lo_sequencer

Overview:
Programmable, glitch-free quadrature LO controller built around the divide-by-4 I/Q clock scheme. It accepts configuration over a valid/ready handshake: divide ratio, sideband select (I/Q swap) and enable. It sequences an internal prescaler and 2-bit phase counter. New settings, including stop, are applied only at a full-period boundary so that out_i/out_q never emit runt pulses. It sits between the register/control plane and the mixer clock inputs.

Parameters:
DIV_W, 8, width of divide-ratio field; output frequency = f_clk / (4 * div_eff)
RST_DIV, 1, divide ratio loaded at reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
cfg_valid  input  1  configuration word valid
cfg_ready  output  1  block can accept configuration
cfg_div  input  DIV_W  divide ratio; 0 treated as 1
cfg_swap  input  1  0 = Q lags I by 90 deg, 1 = Q leads I by 90 deg
cfg_en  input  1  1 = run, 0 = stop at next boundary
out_i  output  1  in-phase clock, registered
out_q  output  1  quadrature clock, registered
running  output  1  1 while generating
phase  output  2  current phase index 0..3

Behaviour:
- Reset (rst=0, async): state=IDLE, prescaler=0, phase=0, div=RST_DIV, swap=0, out_i=0, out_q=0, running=0, cfg_ready=1. Reset mid-run truncates pulses immediately; this is accepted.
- Handshake: transfer occurs when cfg_valid && cfg_ready at a rising edge. cfg_ready = (state != PEND). cfg_ready is combinational from state only and never depends on cfg_valid.
- div_eff = (cfg_div == 0) ? 1 : cfg_div.
- Prescaler counts 0..div_eff-1. Terminal count (tc) = prescaler == div_eff-1. On tc, the prescaler wraps to 0 and phase increments mod 4.
- Boundary = tc && phase == 3, i.e. the last cycle of a full output period.
- Decode is registered and updated together with phase, so outputs reflect the current phase:
  - out_i = 1 in phases 1,2.
  - swap=0: out_q = 1 in phases 2,3.
  - swap=1: out_q = 1 in phases 0,1.
  - Both patterns finish every pulse within the period, so at each boundary no output is mid-pulse. Duty cycle is 50%.
- FSM:
  - IDLE: outputs 0, running=0, phase=0. On transfer, load div/swap. If cfg_en=1, go to RUN; the first phase-0 cycle is the next cycle. If cfg_en=0, stay in IDLE with the values stored.
  - RUN: free-running. On transfer, capture into the shadow registers (div, swap, en) and go to PEND.
  - PEND: keep running with the old settings. At the boundary, apply the shadow values:
    - shadow en=1: go to RUN; the next cycle is phase 0 with the new div/swap and prescaler=0.
    - shadow en=0: go to IDLE; outputs are 0 and running=0 from the next cycle.
- Transfer in RUN coincident with a boundary: the shadow is captured and applied at the following boundary, not the current one.
- Settings in force are never modified except at a boundary or in IDLE.
- Latency: accept in IDLE → running=1 and phase=0 one cycle later; out_i first rises at cycle 1+div_eff after accept.

Decomposition:
- Package quad_lo_pkg:
  - state encoding IDLE/RUN/PEND
  - phase constants PH0..PH3
  - I/Q pattern masks: I=4'b0110, Q_LAG=4'b1100, Q_LEAD=4'b0011 (indexed by phase)
- One sub-module, quadrature_phase_gen: prescaler, phase counter, tc/boundary flags and registered I/Q decode. Inputs are div_eff, swap, run and load.
- The top level holds the FSM, shadow registers and handshake.

Test Plan:
- Reset, then accept div=1, swap=0, en=1 → from the next cycle phase=0,1,2,3 repeating. out_i = 0,1,1,0 and out_q = 0,0,1,1, period 4 cycles. cfg_ready stays 1.
- Accept div=3, swap=1 → period 12. out_i high for phase-1..2 cycles (6 clocks). out_q high for phase-0..1 cycles. Q leads I by 3 clocks.
- While running div=2, accept div=5 mid-period → cfg_ready=0 until the boundary. The old period (8 clocks) completes, then 20-clock periods follow. No pulse shorter than 4 clocks.
- Accept en=0 while running → stop only after phase-3 tc. Outputs then 0, running=0, cfg_ready=1.
- Accept cfg_div=0 → behaves as div=1 (period 4). Transfer exactly on the boundary cycle → applied at the next boundary, one period later.
- Drop rst low mid-pulse → out_i/out_q/running go 0 asynchronously. After release: IDLE, div=RST_DIV.
